// File: rtl/boid_pixel_writer.sv
// boid_pixel_writer
//
// Turns one boid update record from the accelerator into frame-buffer writes:
// first the footprint at the previous position is erased with BG_COLOR, then
// the footprint at the new position is drawn with the record's colour. Pixels
// outside the frame buffer are skipped, taking one idle cycle each.
//
// Optional feature: define BOID_WRITER_BOX_EN to use a 2x2 box footprint
// ((x,y), (x+1,y), (x,y+1), (x+1,y+1)). Otherwise the footprint is one pixel.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid_i   record available
//   in_ready_o   writer can accept a record (idle)
//   x_i, y_i     new position, signed 16.16 fixed point
//   px_i, py_i   previous position, signed 16.16 fixed point
//   color_i      draw colour
//   mem_addr_o   frame-buffer word address, y*FB_W+x
//   mem_data_o   pixel data
//   mem_we_o     write request; commits when mem_ready_i is also high
//   mem_ready_i  frame-buffer port grant
//   done_o       one-cycle pulse when a record has been fully written
module boid_pixel_writer #(
  parameter int unsigned FB_W     = 640,
  parameter int unsigned FB_H     = 480,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] px_i,
  input  logic [31:0] py_i,
  input  logic [7:0]  color_i,
  output logic [18:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic        done_o
);

`ifdef BOID_WRITER_BOX_EN
  localparam int unsigned NumPix = 4;
`else
  localparam int unsigned NumPix = 1;
`endif
  localparam logic [1:0] LastIdx = 2'(NumPix - 1);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [15:0] x_q, y_q, px_q, py_q;
  logic [7:0]  color_q;
  logic        mem_we_q;
  logic [18:0] mem_addr_q;
  logic [7:0]  mem_data_q;
  logic        in_ready_q;
  logic        done_q;

  // Only the integer part of each coordinate is used.
  logic unused_frac;
  assign unused_frac = ^{x_i[15:0], y_i[15:0], px_i[15:0], py_i[15:0]};

  // Footprint pixel idx of a base coordinate: returns {in_range, address}.
  // idx[0] selects x+1, idx[1] selects y+1.
  function automatic logic [19:0] pix_calc(input logic [15:0] bx, input logic [15:0] by,
                                           input logic [1:0] idx);
    logic signed [17:0] cx;
    logic signed [17:0] cy;
    logic               ok;
    logic [18:0]        a;
    cx = {{2{bx[15]}}, bx} + {17'd0, idx[0]};
    cy = {{2{by[15]}}, by} + {17'd0, idx[1]};
    ok = !cx[17] && !cy[17] && (32'(cx) < FB_W) && (32'(cy) < FB_H);
    a  = 19'(cy) * 19'(FB_W) + 19'(cx);
    return {ok, a};
  endfunction

  // Next pixel to present: coordinate source and footprint index.
  logic [15:0] src_x, src_y;
  logic [1:0]  nxt_idx;
  logic [19:0] nxt_pix;

  always_comb begin
    src_x   = px_q;
    src_y   = py_q;
    nxt_idx = idx_q + 2'd1;
    unique case (state_q)
      StIdle: begin
        src_x   = px_i[31:16];
        src_y   = py_i[31:16];
        nxt_idx = 2'd0;
      end
      StErase: begin
        if (idx_q == LastIdx) begin
          src_x   = x_q;
          src_y   = y_q;
          nxt_idx = 2'd0;
        end
      end
      StDraw: begin
        src_x = x_q;
        src_y = y_q;
      end
      default: ;
    endcase
    nxt_pix = pix_calc(src_x, src_y, nxt_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      px_q       <= 16'd0;
      py_q       <= 16'd0;
      color_q    <= 8'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 19'd0;
      mem_data_q <= 8'd0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            x_q        <= x_i[31:16];
            y_q        <= y_i[31:16];
            px_q       <= px_i[31:16];
            py_q       <= py_i[31:16];
            color_q    <= color_i;
            in_ready_q <= 1'b0;
            state_q    <= StErase;
            idx_q      <= nxt_idx;
            mem_we_q   <= nxt_pix[19];
            mem_addr_q <= nxt_pix[18:0];
            mem_data_q <= BG_COLOR;
          end
        end
        StErase, StDraw: begin
          // A clipped pixel (mem_we_q low) advances after its single cycle.
          if (!mem_we_q || mem_ready_i) begin
            if (state_q == StDraw && idx_q == LastIdx) begin
              state_q  <= StDone;
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              if (state_q == StErase && idx_q == LastIdx) begin
                state_q    <= StDraw;
                mem_data_q <= color_q;
              end
              idx_q      <= nxt_idx;
              mem_we_q   <= nxt_pix[19];
              mem_addr_q <= nxt_pix[18:0];
            end
          end
        end
        StDone: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Testbench for boid_pixel_writer: directed records with hand-computed
// addresses and cycle timings. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. Cycle 0 is the cycle in
// which a record is offered with in_ready high.
module tb_boid_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x, y, px, py;
  logic [7:0]  color;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_dones  = 0;

  boid_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .x_i        (x),
    .y_i        (y),
    .px_i       (px),
    .py_i       (py),
    .color_i    (color),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .mem_we_o   (mem_we),
    .mem_ready_i(mem_ready),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Inputs are stable from just after one rising edge to the next, so a
  // commit sampled here is the one taken at the coming edge.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) n_writes++;
    if (!reset && done) n_dones++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's input-drive point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [31:0] fx(input int v);
    return 32'(v) << 16;
  endfunction

  task automatic load(input int nx, input int ny, input int npx, input int npy,
                      input logic [7:0] c);
    x     = fx(nx);
    y     = fx(ny);
    px    = fx(npx);
    py    = fx(npy);
    color = c;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  int w0, d0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    load(0, 0, 0, 0, 8'h00);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

`ifdef BOID_WRITER_BOX_EN
    // Box footprint: erase at (10,5) fully in range, draw at the corner.
    next_cycle();
    w0 = n_writes;
    load(639, 479, 10, 5, 8'hA5);
    in_valid = 1'b1;
    sample();
    next_cycle();
    in_valid = 1'b0;
    sample();
    check_eq("box_e0_we", 32'(mem_we), 32'd1);
    check_eq("box_e0_addr", 32'(mem_addr), 32'd3210);
    check_eq("box_e0_data", 32'(mem_data), 32'h00);
    next_cycle(); sample();
    check_eq("box_e1_addr", 32'(mem_addr), 32'd3211);
    next_cycle(); sample();
    check_eq("box_e2_addr", 32'(mem_addr), 32'd3850);
    next_cycle(); sample();
    check_eq("box_e3_addr", 32'(mem_addr), 32'd3851);
    next_cycle(); sample();
    check_eq("box_d0_we", 32'(mem_we), 32'd1);
    check_eq("box_d0_addr", 32'(mem_addr), 32'd307199);
    check_eq("box_d0_data", 32'(mem_data), 32'hA5);
    for (int c = 6; c <= 8; c++) begin
      next_cycle(); sample();
      check_eq($sformatf("box_clip_we_c%0d", c), 32'(mem_we), 32'd0);
      check_eq($sformatf("box_clip_done_c%0d", c), 32'(done), 32'd0);
    end
    next_cycle(); sample();
    check_eq("box_done_c9", 32'(done), 32'd1);
    next_cycle(); sample();
    check_eq("box_ready_c10", 32'(in_ready), 32'd1);
    check_eq("box_writes", 32'(n_writes - w0), 32'd5);
`else
    // Basic record, no stalls.
    next_cycle();
    w0 = n_writes; d0 = n_dones;
    load(100, 50, 99, 50, 8'hFF);
    in_valid = 1'b1;
    sample();
    check_eq("basic_ready_c0", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    sample();
    check_eq("basic_ready_c1", 32'(in_ready), 32'd0);
    check_eq("basic_erase_we", 32'(mem_we), 32'd1);
    check_eq("basic_erase_addr", 32'(mem_addr), 32'd32099);
    check_eq("basic_erase_data", 32'(mem_data), 32'h00);
    next_cycle(); sample();
    check_eq("basic_draw_we", 32'(mem_we), 32'd1);
    check_eq("basic_draw_addr", 32'(mem_addr), 32'd32100);
    check_eq("basic_draw_data", 32'(mem_data), 32'hFF);
    check_eq("basic_no_early_done", 32'(done), 32'd0);
    next_cycle(); sample();
    check_eq("basic_done_c3", 32'(done), 32'd1);
    check_eq("basic_we_c3", 32'(mem_we), 32'd0);
    next_cycle(); sample();
    check_eq("basic_ready_c4", 32'(in_ready), 32'd1);
    check_eq("basic_done_c4", 32'(done), 32'd0);
    check_eq("basic_writes", 32'(n_writes - w0), 32'd2);
    check_eq("basic_dones", 32'(n_dones - d0), 32'd1);

    // Stall: mem_ready low in cycles 1-3.
    next_cycle();
    in_valid = 1'b1;
    sample();
    next_cycle();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    sample();
    next_cycle(); sample();
    next_cycle(); sample();
    check_eq("stall_we_c3", 32'(mem_we), 32'd1);
    check_eq("stall_addr_c3", 32'(mem_addr), 32'd32099);
    next_cycle();
    mem_ready = 1'b1;
    sample();
    check_eq("stall_we_c4", 32'(mem_we), 32'd1);
    check_eq("stall_addr_c4", 32'(mem_addr), 32'd32099);
    next_cycle(); sample();
    check_eq("stall_draw_addr_c5", 32'(mem_addr), 32'd32100);
    check_eq("stall_draw_data_c5", 32'(mem_data), 32'hFF);
    next_cycle(); sample();
    check_eq("stall_done_c6", 32'(done), 32'd1);

    // Clip: draw at x=-1 is skipped for one cycle.
    next_cycle();
    w0 = n_writes;
    x = 32'hFFFF0000; y = fx(10); px = fx(0); py = fx(10); color = 8'h11;
    in_valid = 1'b1;
    sample();
    next_cycle();
    in_valid = 1'b0;
    sample();
    check_eq("clip_erase_we", 32'(mem_we), 32'd1);
    check_eq("clip_erase_addr", 32'(mem_addr), 32'd6400);
    next_cycle(); sample();
    check_eq("clip_draw_we", 32'(mem_we), 32'd0);
    check_eq("clip_done_c2", 32'(done), 32'd0);
    next_cycle(); sample();
    check_eq("clip_done_c3", 32'(done), 32'd1);
    check_eq("clip_writes", 32'(n_writes - w0), 32'd1);

    // Back-to-back: in_valid held; second record offered from cycle 1.
    next_cycle();
    w0 = n_writes; d0 = n_dones;
    load(100, 50, 99, 50, 8'hFF);
    in_valid = 1'b1;
    sample();
    next_cycle();
    load(5, 2, 4, 2, 8'h3C);
    sample();
    check_eq("b2b_a_erase_addr", 32'(mem_addr), 32'd32099);
    next_cycle(); sample();
    check_eq("b2b_a_draw_data", 32'(mem_data), 32'hFF);
    next_cycle(); sample();
    check_eq("b2b_ready_c3", 32'(in_ready), 32'd0);
    next_cycle(); sample();
    check_eq("b2b_ready_c4", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    sample();
    check_eq("b2b_b_erase_addr", 32'(mem_addr), 32'd1284);
    check_eq("b2b_b_erase_data", 32'(mem_data), 32'h00);
    next_cycle(); sample();
    check_eq("b2b_b_draw_addr", 32'(mem_addr), 32'd1285);
    check_eq("b2b_b_draw_data", 32'(mem_data), 32'h3C);
    idle_cycles(3);
    sample();
    check_eq("b2b_writes", 32'(n_writes - w0), 32'd4);
    check_eq("b2b_dones", 32'(n_dones - d0), 32'd2);

    // Reset at cycle 1 during a stalled erase.
    next_cycle();
    load(100, 50, 99, 50, 8'hFF);
    in_valid = 1'b1;
    sample();
    next_cycle();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    sample();
    next_cycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    w0 = n_writes; d0 = n_dones;
    sample();
    check_eq("rstmid_we_c2", 32'(mem_we), 32'd0);
    check_eq("rstmid_ready_c2", 32'(in_ready), 32'd1);
    idle_cycles(6);
    sample();
    check_eq("rstmid_writes", 32'(n_writes - w0), 32'd0);
    check_eq("rstmid_dones", 32'(n_dones - d0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boid_pixel_writer.md
BOID_PIXEL_WRITER -- requirements
Module: boid_pixel_writer

Interface
REQ-001 Parameter: FB_W, default 640, frame-buffer width in pixels.
REQ-002 Parameter: FB_H, default 480, frame-buffer height in pixels.
REQ-003 Parameter: BG_COLOR, default 8'h00, colour written when erasing.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  boid update record available from the accelerator.
REQ-007 in_ready  out  1  writer can accept a record.
REQ-008 x_in, y_in  in  32 each  new position, signed 16.16 fixed point.
REQ-009 px_in, py_in  in  32 each  previous position, signed 16.16, to be erased.
REQ-010 color_in  in  8  draw colour.
REQ-011 mem_addr  out  19  frame-buffer word address, y*FB_W+x.
REQ-012 mem_data  out  8  pixel data.
REQ-013 mem_we  out  1  write request.
REQ-014 mem_ready  in  1  frame-buffer port granted; a write commits on a cycle with mem_we and mem_ready both high.
REQ-015 done  out  1  one-cycle pulse when a record is fully written.

Function
REQ-016 States: IDLE, ERASE, DRAW, DONE.
REQ-017 IDLE: in_ready=1. On in_valid&in_ready, latch all inputs and go to ERASE. in_ready=0 in every other state.
REQ-018 Pixel coordinate = integer part, bits [31:16], treated as signed. A pixel is clipped if the coordinate is <0, x>=FB_W, or y>=FB_H.
REQ-019 ERASE: emit one write per erase pixel at (px,py) with mem_data=BG_COLOR. DRAW: emit one write per draw pixel at (x,y) with mem_data=color_in (latched).
REQ-020 Unclipped pixel: hold mem_we=1 with stable addr/data until mem_ready=1, then advance to the next pixel.
REQ-021 Clipped pixel: mem_we=0 for exactly one cycle, then advance. Out-of-range addresses are never driven with mem_we=1.
REQ-022 The last ERASE pixel advances to DRAW. The last DRAW pixel advances to DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 Zero-stall latency, single-pixel mode: accept at cycle 0, erase write at cycle 1, draw write at cycle 2, done at cycle 3, in_ready=1 at cycle 4.
REQ-025 Address = y*FB_W + x, computed in at least 19 bits without truncation. The max in-range address is 307199.
REQ-026 If erase and draw coordinates are equal, both writes are still issued, erase first. The final pixel holds color_in.
REQ-027 When mem_we=0, mem_addr and mem_data are don't-care. The bench checks them only when mem_we=1.

Reset
REQ-028 On reset, force state=IDLE and set mem_we=0, done=0, in_ready=1 on the next cycle. Latched data is cleared to 0.
REQ-029 Reset mid-ERASE or mid-DRAW abandons the record. No further writes are issued and no done pulse is generated.

Configuration
REQ-030 Macro BOID_WRITER_BOX_EN selects the pixel footprint.
- Defined: each erase or draw covers a 2x2 box at (x,y), (x+1,y), (x,y+1), (x+1,y+1), issued in that order; each pixel is clipped independently. Zero-stall latency: accept at 0, erase at 1-4, draw at 5-8, done at 9.
- Undefined: single pixel, latency per REQ-024.

Verification
REQ-031 Basic: mem_ready=1, px=99.0, py=50.0, x=100.0, y=50.0, color=8'hFF. Expect a write of addr 32099 with data 00 at cycle 1, addr 32100 with data FF at cycle 2, done at cycle 3.
REQ-032 Stall: same record, mem_ready=0 for cycles 1-3. Expect addr 32099 held with mem_we=1 through cycle 4 and committed at cycle 4; draw at cycle 5; done at cycle 6.
REQ-033 Clip: x=0xFFFF0000 (-1.0), y=10.0, px=0.0, py=10.0. Expect an erase write at addr 6400, no draw write (mem_we=0 for one cycle), done at cycle 3.
REQ-034 Back-to-back: in_valid held high with two records. Expect the second accepted only at cycle 4, and exactly 4 writes plus 2 done pulses total.
REQ-035 Reset at cycle 1 with mem_ready=0. Expect mem_we=0 at cycle 2 onward, no done pulse, and in_ready=1 at cycle 2.
REQ-036 BOID_WRITER_BOX_EN: draw at x=639.0, y=479.0. Expect only addr 307199 written in DRAW, the other 3 pixels clipped, and done at cycle 9.
